ftsd_scan_ctl: RTL and testbench

Scan controller for the 14-segment display (FTSD). It time-multiplexes N_DIGIT digit patterns onto a shared segment bus, paced by a one-cycle scan tick from the frequency divider. Each digit slot is preceded by an inter-digit blanking interval to suppress ghosting. Pattern updates are double-buffered and applied only at frame boundaries, so a displayed frame never mixes old and new data.

---
 rtl/ftsd_scan_ctl.sv | 169 ++++++++++++++++
 tb/tb_ftsd_scan_ctl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ftsd_scan_ctl.sv
// ftsd_scan_ctl
// Scan controller for a multiplexed 14-segment display. One digit is driven at
// a time on a shared segment bus. Each digit slot is preceded by a blanking
// interval to suppress ghosting. Pacing comes from a one-cycle scan tick
// (scan_en), which is never used as a clock. New frame data is held in a
// staging buffer and copied to the displayed (shadow) frame only at a frame
// boundary or while the display is off. A displayed frame therefore never
// mixes old and new patterns.
module ftsd_scan_ctl #(
    parameter int N_DIGIT     = 4,
    parameter int SEG_W       = 15,
    parameter int BLANK_TICKS = 1,
    parameter int DWELL_TICKS = 2,
    localparam int IDX_W      = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scan_en,
    input  logic                       enable,
    input  logic                       wr_req,
    input  logic [N_DIGIT*SEG_W-1:0]   wr_data,
    output logic                       wr_ack,
    input  logic [N_DIGIT-1:0]         digit_mask,
    output logic [N_DIGIT-1:0]         ftsd_ctl,
    output logic [SEG_W-1:0]           ftsd_seg,
    output logic [IDX_W-1:0]           scan_idx,
    output logic                       frame_done
);

    localparam int FRAME_W = N_DIGIT * SEG_W;
    localparam int CNT_MAX = (BLANK_TICKS > DWELL_TICKS) ? BLANK_TICKS : DWELL_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGIT - 1);

    logic [1:0]         state_q,   state_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [FRAME_W-1:0] shadow_q,  shadow_d;
    logic [FRAME_W-1:0] staging_q, staging_d;
    logic               pending_q, pending_d;

    logic blank_last;
    logic dwell_last;
    logic last_digit;
    logic frame_boundary;
    logic apply_point;
    logic do_apply;
    logic drive_active;

    assign blank_last = (cnt_q == BLANK_LAST);
    assign dwell_last = (cnt_q == DWELL_LAST);
    assign last_digit = (idx_q == IDX_LAST);

    // The frame ends on the final dwell tick of the last digit. This is only
    // true if the display stays enabled through that tick. An abandoned frame
    // produces no frame boundary.
    assign frame_boundary = !rst && enable && (state_q == ST_DRIVE) &&
                            scan_en && dwell_last && last_digit;

    // The shadow frame may change at a frame boundary. It may also change on
    // any cycle in OFF, because nothing is displayed then.
    assign apply_point = !rst && ((state_q == ST_OFF) || frame_boundary);
    assign do_apply    = apply_point && (pending_q || wr_req);

    assign wr_ack     = do_apply;
    assign frame_done = frame_boundary;

    // Next-state logic for the scan sequencer: OFF -> BLANK -> DRIVE -> BLANK ...
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (scan_en) begin
                        if (blank_last) begin
                            state_d = ST_DRIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRIVE: begin
                    if (scan_en) begin
                        if (dwell_last) begin
                            state_d = ST_BLANK;
                            cnt_d   = '0;
                            idx_d   = last_digit ? '0 : idx_q + IDX_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double-buffered frame update. A request on the apply cycle bypasses
    // staging. Otherwise the last request before the apply point wins.
    always_comb begin
        shadow_d  = shadow_q;
        staging_d = staging_q;
        pending_d = pending_q;
        if (do_apply) begin
            shadow_d  = wr_req ? wr_data : staging_q;
            pending_d = 1'b0;
        end else if (wr_req) begin
            staging_d = wr_data;
            pending_d = 1'b1;
        end
    end

    // State registers. Reset blanks the display and discards a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '1;
            staging_q <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
        end
    end

    // A masked slot keeps its timing but stays dark. Select and segments use
    // the same enable term, so they change together.
    assign drive_active = (state_q == ST_DRIVE) && digit_mask[idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGIT; gi++) begin : g_ctl
            assign ftsd_ctl[gi] = !(drive_active && (idx_q == IDX_W'(gi)));
        end
    endgenerate

    assign ftsd_seg = drive_active ? shadow_q[int'(idx_q) * SEG_W +: SEG_W] : {SEG_W{1'b1}};
    assign scan_idx = idx_q;

endmodule

// File: tb/tb_ftsd_scan_ctl.sv
// tb_ftsd_scan_ctl
// Directed scenarios followed by random stimulus. Every cycle is compared
// with a reference model that tracks the position within the frame as a tick
// count (slot = pos / slot_len, phase = pos % slot_len).
module tb_ftsd_scan_ctl;

    localparam int N      = 4;
    localparam int SW     = 15;
    localparam int B      = 1;
    localparam int D      = 2;
    localparam int SLOT   = B + D;
    localparam int PERIOD = N * SLOT;
    localparam int FW     = N * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scan_en = 1'b0;
    logic          enable = 1'b1;
    logic          wr_req = 1'b1;
    logic [FW-1:0] wr_data = '0;
    logic          wr_ack;
    logic [N-1:0]  digit_mask = '1;
    logic [N-1:0]  ftsd_ctl;
    logic [SW-1:0] ftsd_seg;
    logic [1:0]    scan_idx;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit            m_on;
    int            m_pos;
    logic [SW-1:0] m_shadow [N];
    logic [FW-1:0] m_staging;
    bit            m_pending;

    ftsd_scan_ctl #(
        .N_DIGIT(N), .SEG_W(SW), .BLANK_TICKS(B), .DWELL_TICKS(D)
    ) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .enable(enable),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .digit_mask(digit_mask), .ftsd_ctl(ftsd_ctl), .ftsd_seg(ftsd_seg),
        .scan_idx(scan_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[FW-1:0];
    endfunction

    task automatic model_reset();
        m_on      = 1'b0;
        m_pos     = 0;
        m_staging = '0;
        m_pending = 1'b0;
        for (int i = 0; i < N; i++) m_shadow[i] = '1;
    endtask

    // One clock: drive on negedge, check 1 ns later, advance the model at posedge.
    task automatic do_cycle(input logic r, input logic en, input logic wq,
                            input logic [FW-1:0] wd, input logic [N-1:0] mask,
                            input logic sc);
        int            slot;
        int            phase;
        logic [N-1:0]  exp_ctl;
        logic [SW-1:0] exp_seg;
        logic [1:0]    exp_idx;
        bit            bnd;
        bit            app;
        logic [FW-1:0] src;
        @(negedge clk);
        rst = r; enable = en; wr_req = wq; wr_data = wd; digit_mask = mask; scan_en = sc;
        #1;
        slot    = m_pos / SLOT;
        phase   = m_pos % SLOT;
        exp_ctl = '1;
        exp_seg = '1;
        exp_idx = m_on ? 2'(slot) : 2'd0;
        if (m_on && phase >= B && mask[slot]) begin
            exp_ctl[slot] = 1'b0;
            exp_seg       = m_shadow[slot];
        end
        bnd = !r && en && m_on && sc && (m_pos == PERIOD - 1);
        app = !r && (!m_on || bnd) && (m_pending || wq);
        check_val("ctl",  32'(ftsd_ctl),   32'(exp_ctl));
        check_val("seg",  32'(ftsd_seg),   32'(exp_seg));
        check_val("idx",  32'(scan_idx),   32'(exp_idx));
        check_val("ack",  32'(wr_ack),     32'(app));
        check_val("done", 32'(frame_done), 32'(bnd));
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            if (app) begin
                src = wq ? wd : m_staging;
                for (int i = 0; i < N; i++) m_shadow[i] = src[i*SW +: SW];
                m_pending = 1'b0;
            end else if (wq) begin
                m_staging = wd;
                m_pending = 1'b1;
            end
            if (!en) begin
                m_on  = 1'b0;
                m_pos = 0;
            end else if (!m_on) begin
                m_on  = 1'b1;
                m_pos = 0;
            end else if (sc) begin
                m_pos = (m_pos + 1) % PERIOD;
            end
        end
    endtask

    // Regular divider pacing: one scan tick every 4 clocks.
    task automatic step(input logic en, input logic wq, input logic [FW-1:0] wd,
                        input logic [N-1:0] mask);
        do_cycle(1'b0, en, wq, wd, mask, (cyc % 4) == 0);
    endtask

    initial begin
        logic [FW-1:0] f0;
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [N-1:0]  rmask;
        model_reset();
        f0 = {15'h7FF7, 15'h7FFB, 15'h7FFD, 15'h7FFE};

        // Reset held with enable and write request active
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1'b1, rand_frame(), '1, 1'b0);
        step(1'b0, 1'b0, '0, '1);

        // Write while off (bypass ack), then run two frames
        step(1'b0, 1'b1, f0, '1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, '0, '1);

        // Single mid-frame write, then two writes in one frame
        fa = rand_frame();
        fb = rand_frame();
        for (int i = 0; i < 100; i++) step(1'b1, (i == 20), fa, '1);
        for (int i = 0; i < 100; i++) step(1'b1, (i == 10) || (i == 25), (i < 20) ? fa : fb, '1);

        // Masked digits
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, '0, 4'b0101);

        // Drop enable mid-frame with a write pending, then re-enable
        for (int i = 0; i < 30; i++) step(1'b1, (i == 5), fa, '1);
        for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, '0, '1);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, '0, '1);

        // Random stimulus
        rmask = '1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rmask = 4'($urandom);
            do_cycle($urandom_range(0, 199) == 0,
                     $urandom_range(0, 39) != 0,
                     $urandom_range(0, 9) == 0,
                     rand_frame(), rmask,
                     $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
